// File: rtl/mode_capture_pkg.sv
// Shared constants for the mode_capture block.
// Mode names and holding-register state encoding.
package mode_capture_pkg;

  localparam string MODE_SHIFT = "MODE_SHIFT";
  localparam string MODE_COUNT = "MODE_COUNT";

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/mode_capture_hold.sv
// Valid/ack holding register for completed words.
// A word arriving while full is dropped unless ACK frees the slot.
module capture_hold
  import mode_capture_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVF
);

  hold_state_e      state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (load) begin
          q_d     = din;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (load) begin
          if (ACK) q_d = din;
          else     ovf_d = 1'b1;
        end else if (ACK) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign Q     = q_q;
  assign VALID = (state_q == ST_FULL);
  assign OVF   = ovf_q;

endmodule

// File: rtl/mode_capture.sv
// Captures MODULE.O as deserialised words (SHIFT)
// or as rising-edge counts over an EN window (COUNT).
(* MODES = "MODE_SHIFT;MODE_COUNT" *)
(* FASM_FEATURES = "IN_USE" *)
(* FASM_FEATURES_MODE_COUNT = "SEL_MODE_COUNT" *)
module mode_capture
  import mode_capture_pkg::*;
#(
  parameter string MODE  = "",
  parameter int    WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I,
  input  logic             EN,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             load;
  logic [WIDTH-1:0] din;

  generate
    if (MODE == MODE_SHIFT) begin : g_shift
      logic [WIDTH-1:0] acc_q, acc_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [WIDTH-1:0] acc_nxt;

      assign acc_nxt = {acc_q[WIDTH-2:0], I};

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end

      always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        load  = 1'b0;
        din   = '0;
        if (EN) begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            load  = 1'b1;
            din   = acc_nxt;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    end else if (MODE == MODE_COUNT) begin : g_count
      logic [WIDTH-1:0] acc_q, acc_d;
      logic             i_d_q, en_d_q;
      logic             rise;
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] acc_sat;

      assign rise    = EN & I & ~i_d_q;
      assign sum     = {1'b0, acc_q} + {{WIDTH{1'b0}}, rise};
      assign acc_sat = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q  <= '0;
          i_d_q  <= 1'b0;
          en_d_q <= 1'b0;
        end else begin
          acc_q  <= acc_d;
          i_d_q  <= I;
          en_d_q <= EN;
        end
      end

      // rise is gated by EN, so the window-close word is acc_q itself
      always_comb begin
        acc_d = acc_q;
        load  = 1'b0;
        din   = '0;
        if (en_d_q && !EN) begin
          load  = 1'b1;
          din   = acc_sat;
          acc_d = '0;
        end else if (EN) begin
          acc_d = acc_sat;
        end
      end
    end else begin : g_inert
      logic unused_in;
      assign unused_in = ^{I, EN};
      assign load      = 1'b0;
      assign din       = '0;
    end
  endgenerate

  capture_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .ACK  (ACK),
    .Q    (Q),
    .VALID(VALID),
    .OVF  (OVF)
  );

endmodule

// File: tb/tb_mode_capture.sv
// Directed bench for mode_capture in SHIFT, COUNT and inert modes.
module tb_mode_capture;

  logic clk = 1'b0;
  logic rst, I, EN, ACK;

  logic [7:0] sh_q, cn_q, nx_q;
  logic [3:0] c4_q;
  logic sh_v, sh_o, cn_v, cn_o, c4_v, c4_o, nx_v, nx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_capture #(.MODE("MODE_SHIFT"), .WIDTH(8)) u_sh (
    .clk(clk), .rst(rst), .I(I), .EN(EN), .ACK(ACK),
    .Q(sh_q), .VALID(sh_v), .OVF(sh_o));

  mode_capture #(.MODE("MODE_COUNT"), .WIDTH(8)) u_cn (
    .clk(clk), .rst(rst), .I(I), .EN(EN), .ACK(ACK),
    .Q(cn_q), .VALID(cn_v), .OVF(cn_o));

  mode_capture #(.MODE("MODE_COUNT"), .WIDTH(4)) u_c4 (
    .clk(clk), .rst(rst), .I(I), .EN(EN), .ACK(ACK),
    .Q(c4_q), .VALID(c4_v), .OVF(c4_o));

  mode_capture #(.MODE("BOGUS"), .WIDTH(8)) u_nx (
    .clk(clk), .rst(rst), .I(I), .EN(EN), .ACK(ACK),
    .Q(nx_q), .VALID(nx_v), .OVF(nx_o));

  typedef struct {
    logic       i;
    logic       en;
    logic       ack;
    logic [7:0] q;
    logic       v;
    logic       o;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic en, input logic ack,
                     input logic [7:0] q, input logic v, input logic o);
    vec_t t;
    t.i = i; t.en = en; t.ack = ack;
    t.q = q; t.v = v; t.o = o;
    tv.push_back(t);
  endtask

  task automatic add_word(input logic [7:0] w, input logic ack_last,
                          input logic [7:0] qm, input logic vm,
                          input logic om, input logic [7:0] qe,
                          input logic ve, input logic oe);
    for (int b = 7; b >= 0; b--) begin
      if (b == 0) add(w[b], 1'b1, ack_last, qe, ve, oe);
      else        add(w[b], 1'b1, 1'b0, qm, vm, om);
    end
  endtask

  task automatic step(input logic i, input logic en, input logic ack);
    I = i; EN = en; ACK = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; I = 1'b0; EN = 1'b0; ACK = 1'b0;
    #2;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_sh", {sh_q, sh_v, sh_o}, 32'h0);
    chk("rst_cn", {cn_q, cn_v, cn_o}, 32'h0);
    chk("rst_c4", {c4_q, c4_v, c4_o}, 32'h0);
    rst = 1'b0;

    // SHIFT: basic word, ACK, pause, back-pressure
    add_word(8'hB2, 1'b0, 8'h00, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b1, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    add_word(8'h3C, 1'b0, 8'hF0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
    add_word(8'hA5, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
    add_word(8'h69, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h69, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 1'b1);

    foreach (tv[n]) begin
      step(tv[n].i, tv[n].en, tv[n].ack);
      chk($sformatf("shift_vec%0d", n), {sh_q, sh_v, sh_o},
          {tv[n].q, tv[n].v, tv[n].o});
    end

    // reset mid-word clears OVF and the partial word
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_sh", {sh_q, sh_v, sh_o}, 32'h0);
    begin
      logic [7:0] w;
      w = 8'h5A;
      for (int b = 7; b >= 0; b--) step(w[b], 1'b1, 1'b0);
    end
    chk("midrst_word", {sh_q, sh_v, sh_o}, {8'h5A, 1'b1, 1'b0});

    // COUNT: 10 edges in 20 cycles
    do_reset();
    for (int k = 0; k < 20; k++) step(k[0], 1'b1, 1'b0);
    chk("cnt_busy_v", cn_v, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("cnt10", {cn_q, cn_v, cn_o}, {8'd10, 1'b1, 1'b0});
    chk("cnt10_w4", {c4_q, c4_v}, {4'hA, 1'b1});

    // COUNT: 20 edges, saturates at WIDTH=4
    do_reset();
    for (int k = 0; k < 40; k++) step(k[0], 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("cnt20", {cn_q, cn_v}, {8'd20, 1'b1});
    chk("cnt_sat", {c4_q, c4_v, c4_o}, {4'hF, 1'b1, 1'b0});

    // COUNT: one-cycle windows publish 1 then 0
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("win1_one", {cn_q, cn_v}, {8'd1, 1'b1});
    step(1'b1, 1'b0, 1'b1);
    chk("win1_ack", {cn_q, cn_v}, {8'd1, 1'b0});
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("win1_zero", {cn_q, cn_v, cn_o}, {8'd0, 1'b1, 1'b0});

    // edges with EN low are ignored
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(k[0], 1'b0, 1'b0);
    chk("en_low_v", cn_v, 1'b0);

    chk("inert", {nx_q, nx_v, nx_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
